// File: rtl/hsv_stream_ctrl.sv
// Frame sequencer for the hue datapath: accepts one frame of pixels, generates read
// coordinates, tags the fixed-latency pipe and stalls it globally on downstream backpressure.
module hsv_stream_ctrl #(
    parameter int LINE_WIDTH = 640,
    parameter int ROW_NUMBER = 480,
    parameter int LATENCY    = 4,
    parameter int CW         = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          frame_done,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [CW-1:0] in_x,
    output logic [CW-1:0] in_y,
    output logic          pipe_en,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_x,
    output logic [CW-1:0] out_y,
    output logic          out_sof,
    output logic          out_eol,
    output logic          out_eof
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    localparam logic [CW-1:0] X_LAST = CW'(LINE_WIDTH - 1);
    localparam logic [CW-1:0] Y_LAST = CW'(ROW_NUMBER - 1);
    localparam logic [CW-1:0] ONE    = CW'(1);

    state_t        state_reg, state_next;
    logic [CW-1:0] x_reg, x_next;
    logic [CW-1:0] y_reg, y_next;
    logic          accept;

    // Stall only when a real pixel is waiting on a downstream that refuses it.
    assign pipe_en = !(out_valid && !out_ready);
    assign accept  = in_valid && in_ready;
    assign in_x    = x_reg;
    assign in_y    = y_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            x_reg     <= '0;
            y_reg     <= '0;
        end else begin
            state_reg <= state_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        in_ready   = 1'b0;
        busy       = 1'b1;
        frame_done = 1'b0;
        case (state_reg)
            IDLE: begin
                busy   = 1'b0;
                x_next = '0;
                y_next = '0;
                if (start) state_next = RUN;
            end
            RUN: begin
                in_ready = pipe_en;
                if (in_valid && pipe_en) begin
                    if (x_reg == X_LAST) begin
                        x_next = '0;
                        if (y_reg == Y_LAST) begin
                            y_next     = '0;
                            state_next = FLUSH;
                        end else begin
                            y_next = y_reg + ONE;
                        end
                    end else begin
                        x_next = x_reg + ONE;
                    end
                end
            end
            FLUSH: begin
                if (out_valid && out_ready && out_eof) state_next = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Tag pipeline: one {valid, x, y} stage per datapath register, all sharing pipe_en.
    genvar gi;
    generate
        for (gi = 0; gi < LATENCY; gi++) begin : g_stage
            logic          v_reg;
            logic [CW-1:0] tx_reg, ty_reg;
            logic          v_in;
            logic [CW-1:0] tx_in, ty_in;
            if (gi == 0) begin : g_head
                assign v_in  = accept;
                assign tx_in = x_reg;
                assign ty_in = y_reg;
            end else begin : g_body
                assign v_in  = g_stage[gi-1].v_reg;
                assign tx_in = g_stage[gi-1].tx_reg;
                assign ty_in = g_stage[gi-1].ty_reg;
            end
            always_ff @(posedge clk) begin
                if (!rst) begin
                    v_reg  <= 1'b0;
                    tx_reg <= '0;
                    ty_reg <= '0;
                end else if (pipe_en) begin
                    v_reg  <= v_in;
                    tx_reg <= tx_in;
                    ty_reg <= ty_in;
                end
            end
        end
    endgenerate

    assign out_valid = g_stage[LATENCY-1].v_reg;
    assign out_x     = g_stage[LATENCY-1].tx_reg;
    assign out_y     = g_stage[LATENCY-1].ty_reg;
    assign out_sof   = out_valid && (out_x == '0) && (out_y == '0);
    assign out_eol   = out_valid && (out_x == X_LAST);
    assign out_eof   = out_eol && (out_y == Y_LAST);
endmodule

// File: tb/tb_hsv_stream_ctrl.sv
// Self-checking bench for hsv_stream_ctrl: per-cycle comparison against a pixel-index
// reference model, plus literal timing pins for latency, frame end and back-to-back start.
module tb_hsv_stream_ctrl;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int L  = 4;
    localparam int CW = 16;
    localparam int N  = W * H;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic          busy, frame_done, in_ready, pipe_en, out_valid;
    logic [CW-1:0] in_x, in_y, out_x, out_y;
    logic          out_sof, out_eol, out_eof;

    hsv_stream_ctrl #(.LINE_WIDTH(W), .ROW_NUMBER(H), .LATENCY(L), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .frame_done(frame_done),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
        .pipe_en(pipe_en), .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    // Reference model: phase of the frame, pixels accepted so far, and a log of what
    // entered the pipe on every enabled cycle (output = entry from L enabled cycles ago).
    int m_phase = 0;   // 0 idle, 1 run, 2 flush, 3 done
    int m_count = 0;
    int m_en = 0;
    int m_out_idx = 0;
    bit log_v [64];
    int log_p [64];
    int ncyc = 0;
    int n_acc = 0, n_done = 0, n_eof = 0;
    int acc0_cyc = 0, out0_cyc = 0, eof_cyc = 0, done_cyc = 0;

    always @(negedge clk) begin
        logic ev, e_pe, e_ir, acc, hs;
        int   ep;
        ev = 1'b0;
        ep = 0;
        if (m_en >= L) begin
            ev = log_v[(m_en - L) % 64];
            ep = log_p[(m_en - L) % 64];
        end
        e_pe = !(ev && !out_ready);
        e_ir = (m_phase == 1) && e_pe;

        chk("pipe_en", pipe_en, e_pe);
        chk("in_ready", in_ready, e_ir);
        chk("busy", busy, m_phase != 0);
        chk("frame_done", frame_done, m_phase == 3);
        chk("in_x", in_x, m_count % W);
        chk("in_y", in_y, m_count / W);
        chk("out_valid", out_valid, ev);
        if (ev) begin
            chk("out_x", out_x, ep % W);
            chk("out_y", out_y, ep / W);
        end
        chk("out_sof", out_sof, ev && (ep == 0));
        chk("out_eol", out_eol, ev && (ep % W == W - 1));
        chk("out_eof", out_eof, ev && (ep == N - 1));

        if (in_valid && in_ready && in_x == 0 && in_y == 0) acc0_cyc = ncyc;
        if (out_valid && out_ready && out_sof) out0_cyc = ncyc;
        if (out_valid && out_ready && out_eof) begin eof_cyc = ncyc; n_eof++; end
        if (frame_done) begin done_cyc = ncyc; n_done++; end

        acc = in_valid && e_ir;
        hs  = ev && out_ready;
        if (!rst) begin
            m_phase = 0; m_count = 0; m_en = 0; m_out_idx = 0;
        end else begin
            if (e_pe) begin
                log_v[m_en % 64] = acc;
                log_p[m_en % 64] = m_count;
                m_en++;
            end
            if (acc) n_acc++;
            if (hs) begin
                chk("out_order", int'(out_y) * W + int'(out_x), m_out_idx);
                m_out_idx = (m_out_idx + 1) % N;
            end
            case (m_phase)
                0: if (start) m_phase = 1;
                1: if (acc) begin
                       m_count++;
                       if (m_count == N) begin m_count = 0; m_phase = 2; end
                   end
                2: if (hs && ep == N - 1) m_phase = 3;
                default: m_phase = 0;
            endcase
        end
        ncyc++;
    end

    int mode = 0;
    int cyc = 0;
    bit rand_start = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        case (mode)
            0: begin in_valid = 1'b1; out_ready = 1'b1; end
            1: begin in_valid = 1'b1; out_ready = (cyc % 4 == 0) || (cyc % 4 == 3); end
            2: begin in_valid = (cyc % 3 != 0); out_ready = 1'b1; end
            default: begin
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 2) != 0);
            end
        endcase
        if (rand_start) start = busy && ($urandom_range(0, 4) == 0);
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 3000 && n_done < target; i++) tick();
        chk("frame_timeout", n_done >= target, 1);
    endtask

    task automatic run_frame(input int m);
        mode = m;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(n_done + 1);
    endtask

    initial begin
        int base, t_eof;
        repeat (3) tick();
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_pipe_en", pipe_en, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_frame_done", frame_done, 0);

        // Continuous frame with literal timing pins.
        run_frame(0);
        chk("latency", out0_cyc - acc0_cyc, L);
        chk("burst_len", eof_cyc - out0_cyc, N - 1);
        chk("done_after_eof", done_cyc - eof_cyc, 1);

        run_frame(1);   // backpressure
        run_frame(2);   // bubbles
        rand_start = 1'b1;
        run_frame(3);   // random traffic, start pulses while busy
        rand_start = 1'b0;
        start = 1'b0;

        // Reset after 5 accepts, then a complete frame.
        mode = 0;
        tick();
        start = 1'b1;
        base = n_acc;
        tick();
        start = 1'b0;
        for (int i = 0; i < 50 && n_acc < base + 5; i++) tick();
        chk("accept_timeout", n_acc >= base + 5, 1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_x", in_x, 0);
        chk("midrst_in_y", in_y, 0);
        run_frame(0);

        // Back-to-back frames with start held high.
        mode = 0;
        tick();
        start = 1'b1;
        wait_done(n_done + 1);
        t_eof = eof_cyc;
        base = n_acc;
        for (int i = 0; i < 20 && n_acc == base; i++) tick();
        start = 1'b0;
        chk("b2b_gap", acc0_cyc - t_eof, 3);
        wait_done(n_done + 1);
        tick();
        tick();

        chk("frames_done", n_done, 7);
        chk("frames_eof", n_eof, 7);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
